// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions.
//   - Fetch FSM state encoding (REQ / HOLD / DRAIN).
//   - Instruction width, PC increment and the NOP encoding.
package if_fetch_stage_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [1:0] ST_REQ   = 2'd0;  // buffer empty, request outstanding
  localparam logic [1:0] ST_HOLD  = 2'd1;  // buffer full, waiting for ID
  localparam logic [1:0] ST_DRAIN = 2'd2;  // stale request outstanding

  localparam logic [INST_W-1:0] PC_INC = 32'd4;
  localparam logic [INST_W-1:0] NOP    = 32'h0000_0000;

  // Word-align an address by clearing its two low bits.
  function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] a);
    return {a[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
//   Owns the PC, runs a req/ack handshake with a variable-latency
//   instruction memory and buffers one instruction plus its PC+4 until ID
//   consumes it. A redirect reloads the PC and discards any in-flight fetch.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             IF/ID hold from the hazard unit
//   redirect          one-cycle branch/jump taken pulse
//   redirect_pc       redirect target (low two bits ignored)
//   imem_req          fetch request to instruction memory
//   imem_addr         fetch address
//   imem_ack          memory response valid (may be same cycle as request)
//   imem_rdata        instruction data, valid with imem_ack
//   inst_out          buffered instruction
//   pc4_out           buffered instruction address + 4
//   out_valid         buffer holds an instruction
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        out_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_addr;
  logic [1:0]  r_state;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc_next;

  // Request/address decode. In HOLD the request follows stall
  // combinationally so a zero-latency memory can refill every cycle.
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      ST_REQ:   w_req = 1'b1;
      ST_HOLD:  w_req = ~stall;
      ST_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_fetch_addr;
      end
      default:  w_req = 1'b0;
    endcase
    if (rst) w_req = 1'b0;
  end

  assign w_pc_next = r_pc + PC_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_state      <= ST_REQ;
      r_valid      <= 1'b0;
      r_inst       <= NOP;
      r_pc4        <= '0;
    end else if (redirect) begin
      // Redirect wins: drop the buffer (even under stall) and decide what
      // to do with the in-flight request, if any.
      r_pc    <= align_word(redirect_pc);
      r_valid <= 1'b0;
      if (r_state == ST_DRAIN) begin
        // Stale request still outstanding; once it acks there is nothing
        // left to drain.
        if (imem_ack) r_state <= ST_REQ;
      end else if (w_req && imem_ack) begin
        r_state <= ST_REQ;
      end else if (w_req) begin
        r_fetch_addr <= w_addr;
        r_state      <= ST_DRAIN;
      end else begin
        r_state <= ST_REQ;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_pc4   <= w_pc_next;
            r_valid <= 1'b1;
            r_pc    <= w_pc_next;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if (imem_ack) begin
              // Consume and refill on the same edge.
              r_inst <= imem_rdata;
              r_pc4  <= w_pc_next;
              r_pc   <= w_pc_next;
            end else begin
              // Request already issued at r_pc; REQ keeps it alive.
              r_valid      <= 1'b0;
              r_fetch_addr <= r_pc;
              r_state      <= ST_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (imem_ack) r_state <= ST_REQ;
        end
        default: begin
          r_state <= ST_REQ;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;
  assign inst_out  = r_inst;
  assign pc4_out   = r_pc4;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
  logic        out_valid;

  // Memory model: zero-latency (ack follows req) or manually driven ack.
  logic zl;
  logic man_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_ack   = zl ? imem_req : man_ack;
    imem_rdata = imem_addr | 32'h1;
  end

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc4_out(pc4_out), .out_valid(out_valid)
  );

  typedef struct {
    logic        zl;
    logic        ack;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic z, input logic a, input logic s,
                              input logic r, input logic [31:0] rp,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep);
    vec_t v;
    v.zl = z; v.ack = a; v.stall = s; v.redir = r; v.rpc = rp;
    v.req = er; v.addr = ea; v.valid = ev; v.inst = ei; v.pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    zl = 1'b1; man_ack = 1'b0;

    // Zero-latency sequential fetch, then a 3-cycle stall in HOLD
    vecs.push_back(mk(1,0,0,0,0,          1,32'h0,1'b0,32'h0,32'h0));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h4,1'b1,32'h1,32'h4));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h8,1'b1,32'h5,32'h8));
    vecs.push_back(mk(1,0,1,0,0,          0,32'hC,1'b1,32'h9,32'hC));
    vecs.push_back(mk(1,0,1,0,0,          0,32'hC,1'b1,32'h9,32'hC));
    vecs.push_back(mk(1,0,1,0,0,          0,32'hC,1'b1,32'h9,32'hC));
    vecs.push_back(mk(1,0,0,0,0,          1,32'hC,1'b1,32'h9,32'hC));
    // Ack delayed 3 cycles on 0x10
    vecs.push_back(mk(0,0,0,0,0,          1,32'h10,1'b1,32'hD,32'h10));
    vecs.push_back(mk(0,0,0,0,0,          1,32'h10,1'b0,32'hD,32'h10));
    vecs.push_back(mk(0,0,0,0,0,          1,32'h10,1'b0,32'hD,32'h10));
    vecs.push_back(mk(0,1,0,0,0,          1,32'h10,1'b0,32'hD,32'h10));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h14,1'b1,32'h11,32'h14));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h18,1'b1,32'h15,32'h18));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h1C,1'b1,32'h19,32'h1C));
    // Redirect to 0x103 while fetch of 0x20 waits -> DRAIN 0x20
    vecs.push_back(mk(0,0,0,0,0,          1,32'h20,1'b1,32'h1D,32'h20));
    vecs.push_back(mk(0,0,0,1,32'h103,    1,32'h20,1'b0,32'h1D,32'h20));
    vecs.push_back(mk(0,0,0,0,0,          1,32'h20,1'b0,32'h1D,32'h20));
    vecs.push_back(mk(0,1,0,0,0,          1,32'h20,1'b0,32'h1D,32'h20));
    vecs.push_back(mk(0,0,0,0,0,          1,32'h100,1'b0,32'h1D,32'h20));
    // Redirect in the same cycle as an ack
    vecs.push_back(mk(0,1,0,1,32'h200,    1,32'h100,1'b0,32'h1D,32'h20));
    vecs.push_back(mk(0,1,0,0,0,          1,32'h200,1'b0,32'h1D,32'h20));
    // Redirect with stall=1 in HOLD drops the buffered instruction
    vecs.push_back(mk(0,0,1,1,32'h300,    0,32'h204,1'b1,32'h201,32'h204));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h300,1'b0,32'h201,32'h204));
    vecs.push_back(mk(1,0,1,0,0,          0,32'h304,1'b1,32'h301,32'h304));
    // Redirect to an unaligned top address, then PC wrap
    vecs.push_back(mk(1,0,1,1,32'hFFFF_FFFF, 0,32'h304,1'b1,32'h301,32'h304));
    vecs.push_back(mk(1,0,0,0,0,          1,32'hFFFF_FFFC,1'b0,32'h301,32'h304));
    vecs.push_back(mk(1,0,0,0,0,          1,32'h0,1'b1,32'hFFFF_FFFD,32'h0));
    vecs.push_back(mk(0,0,0,0,0,          1,32'h4,1'b1,32'h1,32'h4));

    // Reset state
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc4", pc4_out, 32'h0);
    chk("rst_req2", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      zl = vecs[i].zl; man_ack = vecs[i].ack; stall = vecs[i].stall;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].valid});
      chk($sformatf("v%0d_inst", i), inst_out, vecs[i].inst);
      chk($sformatf("v%0d_pc4", i), pc4_out, vecs[i].pc4);
      tick();
    end

    // Reset during a delayed fetch of 0x4
    zl = 1'b0; man_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("mid_req", {31'b0, imem_req}, 32'h1);
    chk("mid_addr", imem_addr, 32'h4);
    chk("mid_valid", {31'b0, out_valid}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_inst", inst_out, 32'h0);
    rst = 1'b0;
    #1;
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    #1;
    chk("restart_valid", {31'b0, out_valid}, 32'h1);
    chk("restart_inst", inst_out, 32'h1);
    chk("restart_pc4", pc4_out, 32'h4);
    chk("restart_next_addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
